// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler slice.
package obstacle_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 6;

    localparam logic [X_W-1:0] X_START_DEF   = 8'd159;
    localparam int             SPAWN_GAP_DEF = 40;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SPAWN      = 4'd1,
        SCAN       = 4'd2,
        ERASE_REQ  = 4'd3,
        ERASE_WAIT = 4'd4,
        MOVE       = 4'd5,
        DRAW_REQ   = 4'd6,
        DRAW_WAIT  = 4'd7,
        NEXT       = 4'd8
    } sched_state_t;

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Request/complete bus between the scheduler and the shared frame drawer.
interface obstacle_scheduler_if;
    import obstacle_pkg::*;

    logic           drw_req;
    logic [X_W-1:0] drw_x;
    logic [Y_W-1:0] drw_y;
    logic           drw_erase;
    logic           drw_done;

    modport master (output drw_req, drw_x, drw_y, drw_erase, input drw_done);
    modport slave  (input drw_req, drw_x, drw_y, drw_erase, output drw_done);

endinterface

// File: rtl/obstacle_scheduler_spawn_timer.sv
// Spawn-gap down-counter: reloads on a spawn, counts down once per pass
// otherwise, and parks at zero until a spawn actually happens.
module spawn_timer #(
    parameter int GAP = 40,
    parameter int W   = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic step,
    input  logic load,
    output logic zero
);

    logic [W-1:0] cnt;

    // Gap counter; load wins over step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(GAP - 1);
        end else if (step && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle pool sequencer: per frame tick, optionally spawns one obstacle at
// the right edge, then walks every active slot erase -> move left -> draw
// through the single shared frame drawer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for tick && enable
// SPAWN      | load lowest free slot if the gap timer allows, reset index
// SCAN       | test slot[idx] active
// ERASE_REQ  | erase request pulse at old position
// ERASE_WAIT | wait for drawer completion
// MOVE       | retire slot at x==0, otherwise x-1
// DRAW_REQ   | draw request pulse at new position
// DRAW_WAIT  | wait for drawer completion
// NEXT       | advance index or finish the pass
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int             NUM_SLOTS = 4,
    parameter logic [X_W-1:0] X_START   = X_START_DEF,
    parameter int             SPAWN_GAP = SPAWN_GAP_DEF,
    parameter int             GAP_W     = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  tick,
    input  logic [Y_W-1:0]        rand_y,
    output logic                  spawn_ack,
    obstacle_scheduler_if.master  drw,
    output logic                  busy,
    output logic [NUM_SLOTS-1:0]  active_mask
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    sched_state_t         state;
    logic [IDX_W-1:0]     idx;
    logic [X_W-1:0]       slot_x [NUM_SLOTS];
    logic [Y_W-1:0]       slot_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_act;

    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 timer_zero;
    logic                 timer_load;
    logic                 timer_step;

    // Lowest-index free slot (scan downwards so the lowest index wins).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_act[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // spawn_ack is decided on the IDLE->SPAWN edge, so in SPAWN it doubles as
    // the "spawn happens this pass" flag for both the slot load and the timer.
    assign timer_load = (state == SPAWN) && spawn_ack;
    assign timer_step = (state == SPAWN) && !spawn_ack;

    spawn_timer #(
        .GAP (SPAWN_GAP),
        .W   (GAP_W)
    ) u_spawn_timer (
        .clk    (clk),
        .resetn (resetn),
        .step   (timer_step),
        .load   (timer_load),
        .zero   (timer_zero)
    );

    // Sequencer, slot register file and registered drawer outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            idx           <= '0;
            slot_act      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
            spawn_ack     <= 1'b0;
            drw.drw_req   <= 1'b0;
            drw.drw_x     <= '0;
            drw.drw_y     <= '0;
            drw.drw_erase <= 1'b0;
        end else begin
            spawn_ack   <= 1'b0;
            drw.drw_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        spawn_ack <= timer_zero && free_found;
                        state     <= SPAWN;
                    end
                end
                SPAWN: begin
                    if (spawn_ack) begin
                        slot_x[free_idx]   <= X_START;
                        slot_y[free_idx]   <= rand_y;
                        slot_act[free_idx] <= 1'b1;
                    end
                    idx   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    if (slot_act[idx]) begin
                        drw.drw_req   <= 1'b1;
                        drw.drw_x     <= slot_x[idx];
                        drw.drw_y     <= slot_y[idx];
                        drw.drw_erase <= 1'b1;
                        state         <= ERASE_REQ;
                    end else begin
                        state <= NEXT;
                    end
                end
                ERASE_REQ:  state <= ERASE_WAIT;
                ERASE_WAIT: if (drw.drw_done) state <= MOVE;
                MOVE: begin
                    if (slot_x[idx] == '0) begin
                        slot_act[idx] <= 1'b0;
                        state         <= NEXT;
                    end else begin
                        slot_x[idx]   <= slot_x[idx] - 1'b1;
                        drw.drw_req   <= 1'b1;
                        drw.drw_x     <= slot_x[idx] - 1'b1;
                        drw.drw_y     <= slot_y[idx];
                        drw.drw_erase <= 1'b0;
                        state         <= DRAW_REQ;
                    end
                end
                DRAW_REQ:  state <= DRAW_WAIT;
                DRAW_WAIT: if (drw.drw_done) state <= NEXT;
                NEXT: begin
                    if (idx == IDX_W'(NUM_SLOTS - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign active_mask = slot_act;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: each accepted tick pushes the
// expected drawer requests; monitors pop and compare as the DUT issues them.
module tb_obstacle_scheduler;
    import obstacle_pkg::*;

    localparam int             NS  = 4;
    localparam int             GAP = 3;
    localparam logic [7:0]     XS  = 8'd159;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          tick;
    logic [5:0]    rand_y;
    logic          spawn_ack;
    logic          busy;
    logic [NS-1:0] active_mask;

    obstacle_scheduler_if drw_if ();

    obstacle_scheduler #(
        .NUM_SLOTS (NS),
        .X_START   (XS),
        .SPAWN_GAP (GAP),
        .GAP_W     (6)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .tick        (tick),
        .rand_y      (rand_y),
        .spawn_ack   (spawn_ack),
        .drw         (drw_if),
        .busy        (busy),
        .active_mask (active_mask)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [14:0] exp_q[$];
    int          tick_cyc = 0;
    int          done_cyc = 0;
    int          ack_cnt  = 0;
    int          first_idx = 0;
    bit          first_pending = 0;
    bit          hold_draw = 0;

    logic [7:0]  m_x   [NS];
    logic [5:0]  m_y   [NS];
    bit          m_act [NS];
    int          m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int model_mask();
        int m = 0;
        for (int i = 0; i < NS; i++) if (m_act[i]) m |= (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = '0; m_y[i] = '0; m_act[i] = 0;
        end
        m_cnt = 0;
    endtask

    // Expected outcome of one accepted tick: spawn decision plus the ordered requests.
    task automatic model_tick(input logic [5:0] y, output bit ack_exp, output int fi);
        ack_exp = 0;
        fi = -1;
        if (m_cnt == 0) begin
            for (int i = 0; i < NS; i++) begin
                if (!m_act[i] && !ack_exp) begin
                    m_act[i] = 1; m_x[i] = XS; m_y[i] = y; ack_exp = 1;
                end
            end
            if (ack_exp) m_cnt = GAP - 1;
        end else begin
            m_cnt--;
        end
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (fi < 0) fi = i;
                exp_q.push_back({m_x[i], m_y[i], 1'b1});
                if (m_x[i] == 8'd0) begin
                    m_act[i] = 0;
                end else begin
                    m_x[i] = m_x[i] - 8'd1;
                    exp_q.push_back({m_x[i], m_y[i], 1'b0});
                end
            end
        end
    endtask

    // Request monitor: compare each drawer request with the scoreboard head.
    always @(negedge clk) begin : mon_req
        logic [14:0] e;
        if (drw_if.drw_req) begin
            chk("req_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("req_x", int'(drw_if.drw_x), int'(e[14:7]));
                chk("req_y", int'(drw_if.drw_y), int'(e[6:1]));
                chk("req_erase", int'(drw_if.drw_erase), int'(e[0]));
            end
            if (first_pending) begin
                chk("first_req_lat", cyc, tick_cyc + 3 + 2 * first_idx);
                first_pending = 0;
            end
            if (!drw_if.drw_erase) chk("draw_lat", cyc, done_cyc + 2);
        end
    end

    // Spawn monitor: count acks and check they land one cycle after the tick.
    always @(negedge clk) begin
        if (spawn_ack) begin
            ack_cnt++;
            chk("ack_lat", cyc, tick_cyc + 1);
        end
    end

    // Drawer model: completes each request two cycles after it is seen.
    initial begin
        drw_if.drw_done = 1'b0;
        forever begin
            @(negedge clk);
            if (drw_if.drw_req && !(hold_draw && !drw_if.drw_erase)) begin
                @(negedge clk);
                @(negedge clk);
                drw_if.drw_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                drw_if.drw_done = 1'b0;
            end
        end
    end

    task automatic tick_pass(input logic [5:0] y, input bit extra, input bit drop_en);
        bit ack_exp;
        int fi;
        model_tick(y, ack_exp, fi);
        @(negedge clk);
        first_idx = fi;
        first_pending = (fi >= 0);
        ack_cnt = 0;
        rand_y = y;
        tick = 1'b1;
        tick_cyc = cyc;
        @(negedge clk);
        tick = 1'b0;
        if (drop_en) enable = 1'b0;
        if (extra) begin
            for (int n = 0; n < 50 && !drw_if.drw_req; n++) @(negedge clk);
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        for (int n = 0; n < 400 && busy; n++) @(negedge clk);
        chk("pass_done", int'(busy), 0);
        chk("spawn_ack_cnt", ack_cnt, int'(ack_exp));
        chk("req_left", exp_q.size(), 0);
        chk("active_mask", int'(active_mask), model_mask());
        enable = 1'b1;
        if (extra) begin
            repeat (4) @(negedge clk);
            chk("no_extra_pass", int'(busy), 0);
        end
    endtask

    initial begin
        bit a;
        int f;
        resetn = 1'b0; enable = 1'b0; tick = 1'b0; rand_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mask", int'(active_mask), 0);
        chk("rst_ack", int'(spawn_ack), 0);
        chk("rst_req", int'(drw_if.drw_req), 0);
        chk("rst_x", int'(drw_if.drw_x), 0);
        chk("rst_y", int'(drw_if.drw_y), 0);
        chk("rst_erase", int'(drw_if.drw_erase), 0);
        enable = 1'b1;

        // single spawn: erase at 159, draw at 158
        tick_pass(6'h15, 0, 0);
        chk("t1_hold_x", int'(drw_if.drw_x), 158);
        chk("t1_hold_y", int'(drw_if.drw_y), 'h15);
        chk("t1_hold_erase", int'(drw_if.drw_erase), 0);
        chk("t1_mask", int'(active_mask), 'h1);

        // gap of 3: ticks 2,3 no spawn, tick 4 spawns slot 1
        tick_pass(6'h02, 0, 0);
        tick_pass(6'h03, 0, 0);
        tick_pass(6'h2A, 0, 0);
        chk("t2_mask", int'(active_mask), 'h3);

        // dropped ticks: enable low in IDLE, then a tick during ERASE_WAIT
        enable = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_low_drop", int'(busy), 0);
        enable = 1'b1;
        tick_pass(6'h11, 1, 0);
        tick_pass(6'h12, 0, 1);

        // fill the pool, then a tick with no free slot
        for (int t = 7; t <= 14; t++) tick_pass(6'(t), 0, 0);
        chk("t3_full_mask", int'(active_mask), 'hF);

        // march the pool down to the left edge
        for (int t = 15; t <= 158; t++) tick_pass(6'(t * 5), 0, 0);
        for (int t = 159; t <= 167; t++) begin
            tick_pass(6'(t), 0, 0);
            if (t == 160) chk("t4_retire_mask", int'(active_mask), 'hE);
            if (t == 166) chk("t3_slot2_free", int'(active_mask), 'hB);
            if (t == 167) chk("t3_respawn_slot2", int'(active_mask), 'hF);
        end

        // reset during DRAW_WAIT, then a late completion
        hold_draw = 1;
        model_tick(6'h30, a, f);
        @(negedge clk);
        first_idx = f; first_pending = (f >= 0); ack_cnt = 0;
        rand_y = 6'h30; tick = 1'b1; tick_cyc = cyc;
        @(negedge clk);
        tick = 1'b0;
        for (int n = 0; n < 100 && !(drw_if.drw_req && !drw_if.drw_erase); n++) @(negedge clk);
        chk("t6_draw_seen", int'(drw_if.drw_req && !drw_if.drw_erase), 1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        drw_if.drw_done = 1'b1;
        exp_q.delete();
        first_pending = 0;
        model_reset();
        @(negedge clk);
        drw_if.drw_done = 1'b0;
        hold_draw = 0;
        repeat (10) @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_mask", int'(active_mask), 0);
        chk("t6_x", int'(drw_if.drw_x), 0);
        chk("t6_erase", int'(drw_if.drw_erase), 0);
        tick_pass(6'h07, 0, 0);
        chk("t6_recover_mask", int'(active_mask), 'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
